spi_byte_transceiver: RTL and testbench

SPI_BYTE_TRANSCEIVER -- requirements
Module: spi_byte_transceiver

---
 rtl/spi_byte_transceiver_if.sv | 23 ++
 rtl/spi_byte_transceiver.sv | 124 ++++++++++++
 tb/tb_spi_byte_transceiver.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_byte_transceiver_if.sv
// Bus between the SPI byte transceiver and its surroundings: SPI pins plus
// the byte-level handshake with the instruction handler.
interface spi_byte_transceiver_if;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] spi_tx_byte;
  logic [7:0] spi_rx_byte;
  logic       spi_rx_valid;
  logic       spi_frame_active;
  logic       spi_frame_abort;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, spi_tx_byte,
    output spi_miso, spi_rx_byte, spi_rx_valid, spi_frame_active, spi_frame_abort
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, spi_tx_byte,
    input  spi_miso, spi_rx_byte, spi_rx_valid, spi_frame_active, spi_frame_abort
  );
endinterface

// File: rtl/spi_byte_transceiver.sv
// SPI mode-0 slave byte transceiver, oversampled by clk; pins are synchronized
// and edges detected in the clk domain.
//
// state  | meaning
// IDLE   | CS deasserted, SCLK ignored, MISO parked at IDLE_MISO
// ACTIVE | frame in progress, bits shifted on synchronized SCLK edges
module spi_byte_transceiver #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  spi_byte_transceiver_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic [7:0]             r_rx_sr;
  logic [7:0]             r_tx_sr;
  logic [2:0]             r_cnt;
  logic [7:0]             r_rx_byte;
  logic                   r_rx_valid;
  logic                   r_abort;
  logic                   r_miso;

  logic w_sclk, w_cs, w_mosi;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_fall   = ~w_cs & r_cs_d;
  assign w_cs_rise   = w_cs & ~r_cs_d;

  // Presets match idle pin levels so reset release never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_next = ACTIVE;
      ACTIVE:  if (w_cs_rise) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_sr    <= 8'h00;
      r_tx_sr    <= 8'h00;
      r_cnt      <= 3'd0;
      r_rx_byte  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_abort    <= 1'b0;
      r_miso     <= IDLE_MISO;
    end else begin
      r_rx_valid <= 1'b0;
      r_abort    <= 1'b0;
      if (r_state == IDLE) begin
        r_miso <= IDLE_MISO;
        if (w_cs_fall) begin
          r_tx_sr <= bus.spi_tx_byte;
          r_miso  <= bus.spi_tx_byte[7];
          r_cnt   <= 3'd0;
        end
      end else if (w_cs_rise) begin
        // CS wins over a coincident SCLK edge; partial bytes are dropped.
        r_abort <= (r_cnt != 3'd0);
        r_cnt   <= 3'd0;
        r_miso  <= IDLE_MISO;
      end else if (w_sclk_rise) begin
        r_rx_sr <= {r_rx_sr[6:0], w_mosi};
        r_cnt   <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_rx_byte  <= {r_rx_sr[6:0], w_mosi};
          r_rx_valid <= 1'b1;
        end
      end else if (w_sclk_fall) begin
        if (r_cnt != 3'd0) begin
          r_tx_sr <= {r_tx_sr[6:0], 1'b0};
          r_miso  <= r_tx_sr[6];
        end else begin
          r_tx_sr <= bus.spi_tx_byte;
          r_miso  <= bus.spi_tx_byte[7];
        end
      end
    end
  end

  assign bus.spi_miso         = r_miso;
  assign bus.spi_rx_byte      = r_rx_byte;
  assign bus.spi_rx_valid     = r_rx_valid;
  assign bus.spi_frame_active = (r_state == ACTIVE);
  assign bus.spi_frame_abort  = r_abort;

endmodule

// File: tb/tb_spi_byte_transceiver.sv
// Self-checking bench for spi_byte_transceiver: a mode-0 SPI master at f_clk/8,
// a byte handler that refills spi_tx_byte after each spi_rx_valid, and monitors.
module tb_spi_byte_transceiver;
  localparam int   SS        = 2;
  localparam logic IDLE_MISO = 1'b0;

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] tx;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  spi_byte_transceiver_if bus();

  spi_byte_transceiver #(.SYNC_STAGES(SS), .IDLE_MISO(IDLE_MISO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         rise8_cyc = 0;
  int         pulse_cnt = 0;
  int         abort_cnt = 0;
  bit         check_idle = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] mosi_list[16];
  logic [7:0] tx_list[16];
  logic [7:0] miso_got[16];
  logic [3:0] tx_idx = 4'd0;
  int         tx_n = 1;

  assign bus.spi_tx_byte = tx_list[tx_idx];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pulse width, latency from the 8th SCLK rise, byte capture, idle levels.
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.spi_rx_valid) begin
        check("rx_valid_width", {31'd0, prev_valid}, 32'd0);
        check("rx_valid_latency_ok", {31'd0, (cyc - rise8_cyc) <= SS + 2}, 32'd1);
        rx_q.push_back(bus.spi_rx_byte);
        pulse_cnt++;
      end
      if (bus.spi_frame_abort) abort_cnt++;
      if (check_idle) begin
        check("idle_miso", {31'd0, bus.spi_miso}, {31'd0, IDLE_MISO});
        check("idle_frame_active", {31'd0, bus.spi_frame_active}, 32'd0);
      end
      prev_valid = bus.spi_rx_valid;
    end
  end

  // Handler: next byte presented the cycle after each spi_rx_valid.
  initial forever begin
    @(negedge clk);
    if (bus.spi_cs_n) tx_idx = 4'd0;
    else if (bus.spi_rx_valid && (int'(tx_idx) + 1 < tx_n)) begin
      @(posedge clk);
      #1;
      tx_idx = tx_idx + 4'd1;
    end
  end

  task automatic send_bits(input logic [7:0] b, input int nb, output logic [7:0] m);
    m = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      bus.spi_mosi = b[i];
      wait_clk(4);
      m[i] = bus.spi_miso;
      bus.spi_sclk = 1'b1;
      if (i == 0) rise8_cyc = cyc;
      wait_clk(4);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input int n);
    logic [7:0] m;
    rx_q.delete();
    tx_n = n;
    wait_clk(2);
    bus.spi_cs_n = 1'b0;
    wait_clk(8);
    check("frame_active_in_frame", {31'd0, bus.spi_frame_active}, 32'd1);
    for (int k = 0; k < n; k++) begin
      send_bits(mosi_list[k], 8, m);
      miso_got[k] = m;
    end
    wait_clk(4);
    bus.spi_cs_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic verify_frame(input int n);
    check("rx_count", rx_q.size(), n);
    for (int k = 0; k < n && k < rx_q.size(); k++) begin
      check("rx_byte_seq", {24'd0, rx_q[k]}, {24'd0, mosi_list[k]});
      check("miso_byte_seq", {24'd0, miso_got[k]}, {24'd0, tx_list[k]});
    end
    check("rx_byte_held", {24'd0, bus.spi_rx_byte}, {24'd0, mosi_list[n-1]});
  endtask

  initial begin
    vec_t       vecs[6];
    logic [7:0] m;
    logic [7:0] held;
    int         p0, a0, nb;

    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[4] = '{8'h80, 8'h01, 8'h80, 8'h01};
    vecs[5] = '{8'h01, 8'h80, 8'h01, 8'h80};

    for (int k = 0; k < 16; k++) tx_list[k] = 8'h00;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    wait_clk(4);
    check("rst_rx_byte", {24'd0, bus.spi_rx_byte}, 32'd0);
    check("rst_rx_valid", {31'd0, bus.spi_rx_valid}, 32'd0);
    check("rst_frame_active", {31'd0, bus.spi_frame_active}, 32'd0);
    check("rst_frame_abort", {31'd0, bus.spi_frame_abort}, 32'd0);
    check("rst_miso", {31'd0, bus.spi_miso}, {31'd0, IDLE_MISO});
    rst = 1'b0;
    wait_clk(4);

    for (int v = 0; v < 6; v++) begin
      mosi_list[0] = vecs[v].mosi;
      tx_list[0]   = vecs[v].tx;
      run_frame(1);
      check("vec_rx_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check("vec_rx_byte", {24'd0, rx_q[0]}, {24'd0, vecs[v].exp_rx});
      check("vec_miso", {24'd0, miso_got[0]}, {24'd0, vecs[v].exp_miso});
      check("vec_rx_out", {24'd0, bus.spi_rx_byte}, {24'd0, vecs[v].exp_rx});
    end

    // Two-byte frame with handler refill.
    mosi_list[0] = 8'h01; mosi_list[1] = 8'hFF;
    tx_list[0]   = 8'h3C; tx_list[1]   = 8'h77;
    run_frame(2);
    verify_frame(2);

    // Abort after 5 bits.
    held = bus.spi_rx_byte;
    p0 = pulse_cnt; a0 = abort_cnt;
    wait_clk(2);
    bus.spi_cs_n = 1'b0;
    wait_clk(8);
    send_bits(8'hB7, 5, m);
    wait_clk(4);
    bus.spi_cs_n = 1'b1;
    wait_clk(12);
    check("abort_no_valid", pulse_cnt - p0, 0);
    check("abort_pulses", abort_cnt - a0, 1);
    check("abort_rx_held", {24'd0, bus.spi_rx_byte}, {24'd0, held});
    mosi_list[0] = 8'h5A; tx_list[0] = 8'h96;
    run_frame(1);
    verify_frame(1);

    // SCLK activity with CS high.
    held = bus.spi_rx_byte;
    p0 = pulse_cnt;
    check_idle = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.spi_mosi = i[0];
      bus.spi_sclk = ~bus.spi_sclk;
      wait_clk(4);
    end
    wait_clk(6);
    check_idle = 1'b0;
    check("idle_no_valid", pulse_cnt - p0, 0);
    check("idle_rx_held", {24'd0, bus.spi_rx_byte}, {24'd0, held});

    // Reset mid-frame.
    p0 = pulse_cnt; a0 = abort_cnt;
    tx_list[0] = 8'hE7;
    wait_clk(2);
    bus.spi_cs_n = 1'b0;
    wait_clk(8);
    send_bits(8'hC3, 4, m);
    rst = 1'b1;
    bus.spi_cs_n = 1'b1;
    wait_clk(3);
    check("midrst_rx_byte", {24'd0, bus.spi_rx_byte}, 32'd0);
    check("midrst_rx_valid", {31'd0, bus.spi_rx_valid}, 32'd0);
    check("midrst_frame_active", {31'd0, bus.spi_frame_active}, 32'd0);
    check("midrst_frame_abort", {31'd0, bus.spi_frame_abort}, 32'd0);
    check("midrst_miso", {31'd0, bus.spi_miso}, {31'd0, IDLE_MISO});
    rst = 1'b0;
    wait_clk(8);
    check("midrst_no_valid", pulse_cnt - p0, 0);
    check("midrst_no_abort", abort_cnt - a0, 0);
    mosi_list[0] = 8'h81; tx_list[0] = 8'h42;
    run_frame(1);
    verify_frame(1);

    // Sixteen back-to-back bytes.
    p0 = pulse_cnt;
    for (int k = 0; k < 16; k++) begin
      mosi_list[k] = k[7:0];
      tx_list[k]   = 8'hF0 ^ (k[7:0] * 8'd17);
    end
    run_frame(16);
    verify_frame(16);
    check("b2b_pulses", pulse_cnt - p0, 16);

    // Randomized frames against the queue model.
    for (int f = 0; f < 10; f++) begin
      nb = $urandom_range(1, 4);
      a0 = abort_cnt;
      for (int k = 0; k < nb; k++) begin
        mosi_list[k] = 8'($urandom_range(0, 255));
        tx_list[k]   = 8'($urandom_range(0, 255));
      end
      run_frame(nb);
      verify_frame(nb);
      check("rand_no_abort", abort_cnt - a0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
